// File: rtl/kram_loader.sv
// KRAM write-side loader: scatters a weight stream round-robin across the PE_NUM banks of one slot.
// Optional stream checksum enabled by defining KRAM_LOADER_CHECKSUM_EN.
module kram_loader #(
    parameter int unsigned PE_NUM  = 8,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned KADDR_W = 10,
    parameter int unsigned CNT_W   = KADDR_W + $clog2(PE_NUM) + 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic                              cmd_slot,
    input  logic [CNT_W-1:0]                  cmd_words,
    input  logic                              s_valid,
    output logic                              s_ready,
    input  logic [DATA_W-1:0]                 s_data,
    input  logic                              s_last,
    input  logic                              cu_busy,
    input  logic                              cu_slot,
    output logic [2*PE_NUM-1:0][KADDR_W-1:0]  bram_addr,
    output logic [2*PE_NUM-1:0][DATA_W-1:0]   bram_wdata,
    output logic [2*PE_NUM-1:0]               bram_we,
    output logic [2*PE_NUM-1:0]               bram_en,
    output logic                              done,
    output logic                              err,
    output logic [1:0]                        slot_loaded,
    output logic [DATA_W-1:0]                 cksum
);
    localparam int unsigned BANK_W = $clog2(2 * PE_NUM);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_LOAD, S_DRAIN, S_DONE} state_t;

    state_t              state_q;
    logic                slot_q;
    logic [CNT_W-1:0]    words_q;
    logic [CNT_W-1:0]    k_q;
    logic                pend_q;
    logic [BANK_W-1:0]   bank_q;
    logic [KADDR_W-1:0]  waddr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                done_q;
    logic                err_q;
    logic [1:0]          loaded_q;

    logic                conflict;
    logic                hs;
    logic                last_beat;
    logic                cmd_acc;
    logic [BANK_W-1:0]   bank_d;
    logic [KADDR_W-1:0]  waddr_d;

    assign conflict  = cu_busy && (cu_slot == slot_q);
    assign cmd_ready = (state_q == S_IDLE);
    assign cmd_acc   = cmd_ready && cmd_valid;
    assign s_ready   = (state_q == S_LOAD) && !conflict && (k_q < words_q);
    assign hs        = s_valid && s_ready;
    assign last_beat = (k_q == words_q - CNT_W'(1));

    assign bank_d  = slot_q ? BANK_W'(PE_NUM + k_q % CNT_W'(PE_NUM))
                            : BANK_W'(k_q % CNT_W'(PE_NUM));
    assign waddr_d = KADDR_W'(k_q / CNT_W'(PE_NUM));

    // done and the slot_loaded update are registered off the DONE state,
    // so they become visible one cycle after it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            slot_q   <= 1'b0;
            words_q  <= '0;
            k_q      <= '0;
            pend_q   <= 1'b0;
            bank_q   <= '0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            loaded_q <= '0;
        end else begin
            done_q <= 1'b0;
            pend_q <= hs;
            if (hs) begin
                bank_q  <= bank_d;
                waddr_q <= waddr_d;
                wdata_q <= s_data;
                k_q     <= k_q + CNT_W'(1);
                if (s_last != last_beat) err_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        slot_q   <= cmd_slot;
                        words_q  <= cmd_words;
                        k_q      <= '0;
                        err_q    <= 1'b0;
                        loaded_q[cmd_slot] <= 1'b0;
                        if (cmd_words == '0)
                            state_q <= S_DONE;
                        else if (cu_busy && (cu_slot == cmd_slot))
                            state_q <= S_WAIT;
                        else
                            state_q <= S_LOAD;
                    end
                end
                S_WAIT:  if (!conflict) state_q <= S_LOAD;
                S_LOAD:  if (hs && last_beat) state_q <= S_DRAIN;
                S_DRAIN: state_q <= S_DONE;
                S_DONE: begin
                    done_q <= 1'b1;
                    if ((words_q != '0) && !err_q) loaded_q[slot_q] <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        bram_addr  = '0;
        bram_wdata = '0;
        bram_we    = '0;
        bram_en    = '0;
        if (pend_q) begin
            bram_addr[bank_q]  = waddr_q;
            bram_wdata[bank_q] = wdata_q;
            bram_we[bank_q]    = 1'b1;
            bram_en[bank_q]    = 1'b1;
        end
    end

    assign done        = done_q;
    assign err         = err_q;
    assign slot_loaded = loaded_q;

`ifdef KRAM_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] cksum_q;

    always_ff @(posedge clk) begin
        if (rst)          cksum_q <= '0;
        else if (cmd_acc) cksum_q <= '0;
        else if (hs)      cksum_q <= cksum_q + s_data;
    end

    assign cksum = cksum_q;
`else
    assign cksum = '0;
`endif

endmodule
